// File: rtl/mbp_chooser.sv
// mbp_chooser: tournament chooser for the multi-branch predictor.
// Picks gbp or lbp per fetch slot from a table of saturating chooser
// counters indexed by PC xor speculative global history, and owns the
// speculative GHR together with its mispredict recovery.
// Optional build macro: MBP_CHOOSER_PERF_EN enables the 32-bit
// gbp/lbp selection counters; without it the perf outputs are tied to 0.
module mbp_chooser #(
  parameter int NR_ENTRIES      = 1024,
  parameter int INSTR_PER_FETCH = 2,
  parameter int HIST_BITS       = 12,
  parameter int CTR_BITS        = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       lookup_valid_i,
  input  logic [63:0]                vpc_i,
  input  logic [INSTR_PER_FETCH-1:0] is_cond_i,
  input  logic [INSTR_PER_FETCH-1:0] gbp_taken_i,
  input  logic [INSTR_PER_FETCH-1:0] lbp_taken_i,
  output logic                       pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] taken_o,
  output logic [INSTR_PER_FETCH-1:0] use_gbp_o,
  output logic [HIST_BITS-1:0]       ghr_o,
  input  logic                       update_valid_i,
  input  logic [63:0]                update_pc_i,
  input  logic [HIST_BITS-1:0]       update_ghr_i,
  input  logic                       update_taken_i,
  input  logic                       update_gbp_ok_i,
  input  logic                       update_lbp_ok_i,
  input  logic                       mispredict_i,
  output logic [31:0]                perf_gbp_cnt_o,
  output logic [31:0]                perf_lbp_cnt_o
);

  localparam int IDX_BITS = $clog2(NR_ENTRIES);
  localparam int CNT_W    = $clog2(INSTR_PER_FETCH + 1);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  // The index is taken from the low history bits, so the history must be
  // at least as wide as the index; counters need a separate MSB for choice.
  generate
    if (HIST_BITS < IDX_BITS) begin : g_bad_hist
      $error("mbp_chooser: HIST_BITS (%0d) must be >= IDX_BITS (%0d)", HIST_BITS, IDX_BITS);
    end
    if (CTR_BITS < 2) begin : g_bad_ctr
      $error("mbp_chooser: CTR_BITS (%0d) must be >= 2", CTR_BITS);
    end
    if ((1 << IDX_BITS) != NR_ENTRIES) begin : g_bad_entries
      $error("mbp_chooser: NR_ENTRIES (%0d) must be a power of 2", NR_ENTRIES);
    end
  endgenerate

  // Chooser table and registered state
  logic [CTR_BITS-1:0]        ctr_q [NR_ENTRIES];
  logic [HIST_BITS-1:0]       ghr_q, ghr_d;
  logic                       pred_valid_q, pred_valid_d;
  logic [INSTR_PER_FETCH-1:0] taken_q, taken_d;
  logic [INSTR_PER_FETCH-1:0] use_gbp_q, use_gbp_d;
  logic [HIST_BITS-1:0]       ghr_out_q, ghr_out_d;

  // Lookup datapath
  logic [IDX_BITS-1:0]        slot_idx [INSTR_PER_FETCH];
  logic [INSTR_PER_FETCH-1:0] slot_use_gbp;
  logic [INSTR_PER_FETCH-1:0] slot_taken;
  logic [INSTR_PER_FETCH-1:0] slot_walked;
  logic [HIST_BITS-1:0]       ghr_walk;
  logic                       walk_stop;

  // Control
  logic recover;
  logic accept;

  // Table write port
  logic [IDX_BITS-1:0] upd_idx;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_d;
  logic                ctr_we;

  assign recover = update_valid_i & mispredict_i;
  assign accept  = lookup_valid_i & ~flush_i & ~recover;

  // Per-slot index, choice and chosen direction. Slot PCs step by 2 bytes, so
  // (vpc + 2*i)[IDX_BITS:1] is simply vpc[IDX_BITS:1] + i with no carry from bit 0.
  always_comb begin
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      slot_idx[i]     = (vpc_i[IDX_BITS:1] + IDX_BITS'(i)) ^ ghr_q[IDX_BITS-1:0];
      slot_use_gbp[i] = ctr_q[slot_idx[i]][CTR_BITS-1];
      slot_taken[i]   = is_cond_i[i] & (slot_use_gbp[i] ? gbp_taken_i[i] : lbp_taken_i[i]);
    end
  end

  // Walk the slots in order, shifting each conditional's chosen direction into
  // the history; the first predicted-taken slot ends the fetch block.
  always_comb begin
    ghr_walk    = ghr_q;
    walk_stop   = 1'b0;
    slot_walked = '0;
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      if (!walk_stop && is_cond_i[i]) begin
        slot_walked[i] = 1'b1;
        ghr_walk       = {ghr_walk[HIST_BITS-2:0], slot_taken[i]};
        if (slot_taken[i]) begin
          walk_stop = 1'b1;
        end
      end
    end
  end

  // Next-state for the GHR and prediction outputs. Recovery overrides the
  // lookup shift; data outputs hold while no prediction is accepted.
  always_comb begin
    ghr_d        = ghr_q;
    pred_valid_d = accept;
    taken_d      = taken_q;
    use_gbp_d    = use_gbp_q;
    ghr_out_d    = ghr_out_q;
    if (recover) begin
      ghr_d = {update_ghr_i[HIST_BITS-2:0], update_taken_i};
    end else if (accept) begin
      ghr_d = ghr_walk;
    end
    if (accept) begin
      taken_d   = slot_taken;
      use_gbp_d = slot_use_gbp;
      ghr_out_d = ghr_q;
    end
  end

  // Chooser counter training: move toward whichever component alone was right.
  always_comb begin
    upd_idx = update_pc_i[IDX_BITS:1] ^ update_ghr_i[IDX_BITS-1:0];
    ctr_cur = ctr_q[upd_idx];
    ctr_d   = ctr_cur;
    ctr_we  = 1'b0;
    if (update_valid_i) begin
      if (update_gbp_ok_i && !update_lbp_ok_i) begin
        if (ctr_cur != CTR_MAX) begin
          ctr_we = 1'b1;
          ctr_d  = ctr_cur + CTR_BITS'(1);
        end
      end else if (!update_gbp_ok_i && update_lbp_ok_i) begin
        if (ctr_cur != '0) begin
          ctr_we = 1'b1;
          ctr_d  = ctr_cur - CTR_BITS'(1);
        end
      end
    end
  end

  // GHR and registered prediction outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      taken_q      <= '0;
      use_gbp_q    <= '0;
      ghr_out_q    <= '0;
    end else begin
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      taken_q      <= taken_d;
      use_gbp_q    <= use_gbp_d;
      ghr_out_q    <= ghr_out_d;
    end
  end

  // Chooser table: all counters start weakly favouring lbp
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int e = 0; e < NR_ENTRIES; e++) begin
        ctr_q[e] <= CTR_INIT;
      end
    end else if (ctr_we) begin
      ctr_q[upd_idx] <= ctr_d;
    end
  end

  assign pred_valid_o = pred_valid_q;
  assign taken_o      = taken_q;
  assign use_gbp_o    = use_gbp_q;
  assign ghr_o        = ghr_out_q;

`ifdef MBP_CHOOSER_PERF_EN
  logic [31:0]      perf_gbp_q, perf_gbp_d;
  logic [31:0]      perf_lbp_q, perf_lbp_d;
  logic [CNT_W-1:0] gbp_inc, lbp_inc;
  logic [32:0]      gbp_sum, lbp_sum;

  // Count walked conditional slots by chosen component, saturating at all-ones
  always_comb begin
    gbp_inc = '0;
    lbp_inc = '0;
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      gbp_inc = gbp_inc + CNT_W'(slot_walked[i] & slot_use_gbp[i]);
      lbp_inc = lbp_inc + CNT_W'(slot_walked[i] & ~slot_use_gbp[i]);
    end
    gbp_sum    = {1'b0, perf_gbp_q} + 33'(gbp_inc);
    lbp_sum    = {1'b0, perf_lbp_q} + 33'(lbp_inc);
    perf_gbp_d = perf_gbp_q;
    perf_lbp_d = perf_lbp_q;
    if (accept) begin
      perf_gbp_d = gbp_sum[32] ? 32'hFFFF_FFFF : gbp_sum[31:0];
      perf_lbp_d = lbp_sum[32] ? 32'hFFFF_FFFF : lbp_sum[31:0];
    end
  end

  // Performance counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_gbp_q <= '0;
      perf_lbp_q <= '0;
    end else begin
      perf_gbp_q <= perf_gbp_d;
      perf_lbp_q <= perf_lbp_d;
    end
  end

  assign perf_gbp_cnt_o = perf_gbp_q;
  assign perf_lbp_cnt_o = perf_lbp_q;
`else
  logic unused_walked;

  assign unused_walked  = ^slot_walked;
  assign perf_gbp_cnt_o = '0;
  assign perf_lbp_cnt_o = '0;
`endif

  // PC bits outside the index field and history bits above it are not needed here
  logic unused_bits;
  assign unused_bits = ^{vpc_i[63:IDX_BITS+1], vpc_i[0],
                         update_pc_i[63:IDX_BITS+1], update_pc_i[0],
                         update_ghr_i};

endmodule

// File: tb/tb_mbp_chooser.sv
// Testbench for mbp_chooser: drives lookups/updates, keeps its own model of
// the chooser table, GHR and perf counters, and compares through a scoreboard.
module tb_mbp_chooser;

  localparam int NR = 1024;
  localparam int HB = 12;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          lookup_valid_i;
  logic [63:0]   vpc_i;
  logic [1:0]    is_cond_i;
  logic [1:0]    gbp_taken_i;
  logic [1:0]    lbp_taken_i;
  logic          pred_valid_o;
  logic [1:0]    taken_o;
  logic [1:0]    use_gbp_o;
  logic [HB-1:0] ghr_o;
  logic          update_valid_i;
  logic [63:0]   update_pc_i;
  logic [HB-1:0] update_ghr_i;
  logic          update_taken_i;
  logic          update_gbp_ok_i;
  logic          update_lbp_ok_i;
  logic          mispredict_i;
  logic [31:0]   perf_gbp_cnt_o;
  logic [31:0]   perf_lbp_cnt_o;

  // Free-running clock
  always #5 clk_i = ~clk_i;

  mbp_chooser dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .lookup_valid_i (lookup_valid_i),
    .vpc_i          (vpc_i),
    .is_cond_i      (is_cond_i),
    .gbp_taken_i    (gbp_taken_i),
    .lbp_taken_i    (lbp_taken_i),
    .pred_valid_o   (pred_valid_o),
    .taken_o        (taken_o),
    .use_gbp_o      (use_gbp_o),
    .ghr_o          (ghr_o),
    .update_valid_i (update_valid_i),
    .update_pc_i    (update_pc_i),
    .update_ghr_i   (update_ghr_i),
    .update_taken_i (update_taken_i),
    .update_gbp_ok_i(update_gbp_ok_i),
    .update_lbp_ok_i(update_lbp_ok_i),
    .mispredict_i   (mispredict_i),
    .perf_gbp_cnt_o (perf_gbp_cnt_o),
    .perf_lbp_cnt_o (perf_lbp_cnt_o)
  );

  typedef struct {
    logic          pv;
    logic [1:0]    taken;
    logic [1:0]    ug;
    logic [HB-1:0] ghr;
    logic [31:0]   pg;
    logic [31:0]   pl;
  } exp_t;

  exp_t          expQ[$];
  int            total = 0;
  int            bad   = 0;

  int            ctrM [NR];
  logic [HB-1:0] ghrM;
  logic [1:0]    lastTaken;
  logic [1:0]    lastUg;
  logic [HB-1:0] lastGhr;
  logic [31:0]   perfG;
  logic [31:0]   perfL;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Fetch PC whose slot 0 lands on the given table index under the model GHR
  function automatic logic [63:0] vpcFor(input int idx);
    logic [9:0] p;
    p = 10'(idx) ^ ghrM[9:0];
    return {53'b0, p, 1'b0};
  endfunction

  function automatic logic [31:0] satAdd(input logic [31:0] a, input int b);
    longint s;
    s = longint'(a) + longint'(b);
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Drive one cycle of stimulus, push the model's expectation, then pop and
  // compare once the registered outputs are available after the clock edge.
  task automatic applyStimulus(input string tag,
                               input logic lv, input logic fl, input logic [63:0] vpc,
                               input logic [1:0] ic, input logic [1:0] g, input logic [1:0] l,
                               input logic uv, input logic [63:0] upc, input logic [HB-1:0] ughr,
                               input logic ut, input logic gok, input logic lok, input logic mis);
    logic          rec, acc, stop;
    logic [1:0]    tk, ug;
    logic [HB-1:0] gw;
    logic [63:0]   pc;
    int            idx, uidx, addG, addL;
    exp_t          e;

    lookup_valid_i  = lv;
    flush_i         = fl;
    vpc_i           = vpc;
    is_cond_i       = ic;
    gbp_taken_i     = g;
    lbp_taken_i     = l;
    update_valid_i  = uv;
    update_pc_i     = upc;
    update_ghr_i    = ughr;
    update_taken_i  = ut;
    update_gbp_ok_i = gok;
    update_lbp_ok_i = lok;
    mispredict_i    = mis;

    rec  = uv & mis;
    acc  = lv & ~fl & ~rec;
    gw   = ghrM;
    stop = 1'b0;
    addG = 0;
    addL = 0;
    for (int i = 0; i < 2; i++) begin
      pc    = vpc + 64'(2 * i);
      idx   = int'(pc[10:1] ^ ghrM[9:0]);
      ug[i] = (ctrM[idx] >= 2);
      tk[i] = ic[i] && (ug[i] ? g[i] : l[i]);
      if (!stop && ic[i]) begin
        gw = {gw[HB-2:0], tk[i]};
        if (ug[i]) addG++;
        else addL++;
        if (tk[i]) stop = 1'b1;
      end
    end
    if (acc) begin
      lastTaken = tk;
      lastUg    = ug;
      lastGhr   = ghrM;
      perfG     = satAdd(perfG, addG);
      perfL     = satAdd(perfL, addL);
    end
    if (rec) ghrM = {ughr[HB-2:0], ut};
    else if (acc) ghrM = gw;
    if (uv) begin
      uidx = int'(upc[10:1] ^ ughr[9:0]);
      if (gok && !lok && ctrM[uidx] < 3) ctrM[uidx]++;
      else if (!gok && lok && ctrM[uidx] > 0) ctrM[uidx]--;
    end

    e.pv    = acc;
    e.taken = lastTaken;
    e.ug    = lastUg;
    e.ghr   = lastGhr;
    e.pg    = perfG;
    e.pl    = perfL;
    expQ.push_back(e);

    @(posedge clk_i);
    #1;
    e = expQ.pop_front();
    checkOutput({tag, "_valid"}, 64'(pred_valid_o), 64'(e.pv));
    checkOutput({tag, "_taken"}, 64'(taken_o), 64'(e.taken));
    checkOutput({tag, "_use_gbp"}, 64'(use_gbp_o), 64'(e.ug));
    checkOutput({tag, "_ghr"}, 64'(ghr_o), 64'(e.ghr));
`ifdef MBP_CHOOSER_PERF_EN
    checkOutput({tag, "_perf_gbp"}, 64'(perf_gbp_cnt_o), 64'(e.pg));
    checkOutput({tag, "_perf_lbp"}, 64'(perf_lbp_cnt_o), 64'(e.pl));
`else
    checkOutput({tag, "_perf_gbp"}, 64'(perf_gbp_cnt_o), 64'd0);
    checkOutput({tag, "_perf_lbp"}, 64'(perf_lbp_cnt_o), 64'd0);
`endif
  endtask

  task automatic doLookup(input string tag, input logic [63:0] vpc,
                          input logic [1:0] ic, input logic [1:0] g, input logic [1:0] l);
    applyStimulus(tag, 1'b1, 1'b0, vpc, ic, g, l, 1'b0, 64'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doUpdate(input string tag, input logic [63:0] pc, input logic [HB-1:0] ghr,
                          input logic gok, input logic lok);
    applyStimulus(tag, 1'b0, 1'b0, 64'd0, 2'b00, 2'b00, 2'b00, 1'b1, pc, ghr, 1'b0, gok, lok, 1'b0);
  endtask

  // Hold reset for two edges with idle inputs and check the cleared outputs
  task automatic doReset(input string tag);
    rst_i           = 1'b1;
    flush_i         = 1'b0;
    lookup_valid_i  = 1'b0;
    vpc_i           = '0;
    is_cond_i       = '0;
    gbp_taken_i     = '0;
    lbp_taken_i     = '0;
    update_valid_i  = 1'b0;
    update_pc_i     = '0;
    update_ghr_i    = '0;
    update_taken_i  = 1'b0;
    update_gbp_ok_i = 1'b0;
    update_lbp_ok_i = 1'b0;
    mispredict_i    = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput({tag, "_valid"}, 64'(pred_valid_o), 64'd0);
    checkOutput({tag, "_taken"}, 64'(taken_o), 64'd0);
    checkOutput({tag, "_use_gbp"}, 64'(use_gbp_o), 64'd0);
    checkOutput({tag, "_ghr"}, 64'(ghr_o), 64'd0);
    checkOutput({tag, "_perf_gbp"}, 64'(perf_gbp_cnt_o), 64'd0);
    checkOutput({tag, "_perf_lbp"}, 64'(perf_lbp_cnt_o), 64'd0);
    rst_i = 1'b0;
    for (int e = 0; e < NR; e++) ctrM[e] = 1;
    ghrM      = '0;
    lastTaken = '0;
    lastUg    = '0;
    lastGhr   = '0;
    perfG     = '0;
    perfL     = '0;
    expQ.delete();
  endtask

  // Directed scenarios followed by a random soak against the model
  initial begin
    $display("[TB] starting mbp_chooser bench");
    doReset("rst");

    // Lookup right after reset: counters weakly lbp, lbp says not-taken
    doLookup("t1", 64'h100, 2'b01, 2'b01, 2'b00);
    checkOutput("t1_const_valid", 64'(pred_valid_o), 64'd1);
    checkOutput("t1_const_use_gbp", 64'(use_gbp_o), 64'd0);
    checkOutput("t1_const_taken", 64'(taken_o), 64'd0);

    // Train index 0x80 toward gbp three times: 1->2->3->3
    for (int k = 0; k < 3; k++) doUpdate("t2_upd", 64'h100, 12'h000, 1'b1, 1'b0);
    doLookup("t2_relookup", vpcFor(12'h080), 2'b01, 2'b01, 2'b00);
    checkOutput("t2_const_use_gbp0", 64'(use_gbp_o[0]), 64'd1);
    checkOutput("t2_const_taken0", 64'(taken_o[0]), 64'd1);

    // Both slots conditional, slot 0 taken via gbp: exactly one shift (GHR 1 -> 3)
    doLookup("t3", vpcFor(12'h080), 2'b11, 2'b11, 2'b11);
    doLookup("t3_ghr", vpcFor(12'h200), 2'b00, 2'b00, 2'b00);
    checkOutput("t3_const_ghr", 64'(ghr_o), 64'h003);

    // Flush without mispredict drops the lookup and leaves the GHR alone
    applyStimulus("flush", 1'b1, 1'b1, vpcFor(5), 2'b01, 2'b01, 2'b01,
                  1'b0, 64'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    doLookup("flush_ghr", 64'h40, 2'b00, 2'b00, 2'b00);
    checkOutput("flush_const_ghr", 64'(ghr_o), 64'h003);

    // Recovery in the same cycle as a lookup wins and kills the prediction
    applyStimulus("t4", 1'b1, 1'b0, vpcFor(12'h010), 2'b01, 2'b01, 2'b01,
                  1'b1, 64'h300, 12'h0A5, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_const_valid", 64'(pred_valid_o), 64'd0);
    doLookup("t4_ghr", 64'h80, 2'b00, 2'b00, 2'b00);
    checkOutput("t4_const_ghr", 64'(ghr_o), 64'h14B);

    // Saturation at 0 with both right, then one increment stays lbp
    doUpdate("t5_dec", 64'h2AA, 12'h000, 1'b0, 1'b1);
    doUpdate("t5_both_ok", 64'h2AA, 12'h000, 1'b1, 1'b1);
    doUpdate("t5_inc", 64'h2AA, 12'h000, 1'b1, 1'b0);
    doLookup("t5_low", vpcFor(12'h155), 2'b01, 2'b00, 2'b00);
    checkOutput("t5_const_low_use_gbp0", 64'(use_gbp_o[0]), 64'd0);

    // Holding at 3 with both wrong, then one decrement stays gbp
    doUpdate("t5_both_bad", 64'h100, 12'h000, 1'b0, 1'b0);
    doUpdate("t5_dec3", 64'h100, 12'h000, 1'b0, 1'b1);
    doLookup("t5_high", vpcFor(12'h080), 2'b01, 2'b00, 2'b00);
    checkOutput("t5_const_high_use_gbp0", 64'(use_gbp_o[0]), 64'd1);

    // Same-cycle update is not bypassed into the lookup
    applyStimulus("bypass", 1'b1, 1'b0, vpcFor(12'h2AA), 2'b01, 2'b01, 2'b00,
                  1'b1, 64'h554, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("bypass_const_old", 64'(use_gbp_o[0]), 64'd0);
    doLookup("bypass_after", vpcFor(12'h2AA), 2'b01, 2'b01, 2'b00);
    checkOutput("bypass_const_new", 64'(use_gbp_o[0]), 64'd1);

    // Random soak over a small PC/history space so counters hit both rails
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rnd",
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                    64'($urandom_range(0, 31)) << 1,
                    2'($urandom), 2'($urandom), 2'($urandom),
                    1'($urandom), 64'($urandom_range(0, 7)) << 1, 12'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom_range(0, 7) == 0));
    end

`ifdef MBP_CHOOSER_PERF_EN
    // Five lbp-choosing lookups, then reset clears both counters
    doReset("perf_rst0");
    for (int k = 0; k < 5; k++) doLookup("perf", vpcFor(12'h100 + k), 2'b01, 2'b00, 2'b00);
    checkOutput("perf_const_lbp", 64'(perf_lbp_cnt_o), 64'd5);
    checkOutput("perf_const_gbp", 64'(perf_gbp_cnt_o), 64'd0);
    doReset("perf_rst1");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
